axi4_lite_master_handshake_engine: RTL
======================================

Name: axi4_lite_master_handshake_engine

Overview:
Master-side (initiator) counterpart of the AXI4-Lite slave interface.
- Accepts single write and read commands from a local request port and drives the AW/W/B and AR/R handshakes toward a slave.
- Returns the completion status to the requester.
- Write and read paths are independent FSMs and may be in flight concurrently, at most one outstanding transaction per direction.
- Sits between the master-agent BFM/driver logic and the AXI4-Lite bus pins.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr and the request addresses.
- DATA_WIDTH, 32, width of wdata/rdata; must be 32 or 64.
- TIMEOUT_CYCLES, 256, number of wait cycles before the sticky timeout flag sets; 0 disables the timeout.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- wr_req_valid  in  1  write command valid.
- wr_req_ready  out  1  write command accepted.
- wr_req_addr  in  ADDR_WIDTH  write address.
- wr_req_data  in  DATA_WIDTH  write data.
- wr_req_strb  in  DATA_WIDTH/8  write strobes.
- wr_done  out  1  one-cycle write completion pulse.
- wr_resp  out  2  BRESP of the completed write.
- rd_req_valid  in  1  read command valid.
- rd_req_ready  out  1  read command accepted.
- rd_req_addr  in  ADDR_WIDTH  read address.
- rd_done  out  1  one-cycle read completion pulse.
- rd_data  out  DATA_WIDTH  read data.
- rd_resp  out  2  RRESP of the completed read.
- timeout_clr  in  1  clears both timeout flags.
- wr_timeout  out  1  sticky write timeout flag.
- rd_timeout  out  1  sticky read timeout flag.
- AXI master-side pins:
  - awvalid out, awready in, awaddr out ADDR_WIDTH.
  - wvalid out, wready in, wdata out, wstrb out.
  - bvalid in, bready out, bresp in 2.
  - arvalid out, arready in, araddr out ADDR_WIDTH.
  - rvalid in, rready out, rdata in, rresp in 2.

Behaviour:
- Reset: all outputs are 0 while aresetn is low, including the valids, bready, rready, done pulses, resp fields, data and timeout flags. Both FSMs return to IDLE. An in-flight transaction is abandoned with no done pulse.
- All outputs are registered. Nothing is combinationally driven from AXI inputs.
- Write FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE: wr_req_ready=1. On wr_req_valid, latch addr/data/strb and go to W_ADDR_DATA. awvalid and wvalid are both high the next cycle.
  - W_ADDR_DATA: awvalid drops the cycle after awready is sampled high. wvalid drops the cycle after wready is sampled high. The two handshakes are independent.
  - W_ADDR_DATA, both handshakes done (same cycle or different cycles): go to W_RESP. bready is high the following cycle.
  - W_RESP: bready=1. On bvalid, latch bresp, pulse wr_done with wr_resp valid the next cycle, drop bready, return to W_IDLE. wr_req_ready is high again in that same cycle.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: rd_req_ready=1. On accept, arvalid is high the next cycle.
  - R_ADDR: on the arready handshake, go to R_DATA with rready high the next cycle.
  - R_DATA: on rvalid, latch rdata/rresp and pulse rd_done the next cycle.
- AXI rules:
  - A valid, once asserted, stays high with stable payload until its handshake.
  - No valid waits on a ready.
  - bvalid/rvalid outside W_RESP/R_DATA are ignored, since bready/rready are low.
- Latency with a zero-wait slave: request accept at cycle N; AW/W handshake at N+1; B handshake at N+2; wr_done at N+3. Reads follow the same timing.
- Response fields: wr_resp/rd_resp/rd_data hold their last value until the next completion.
- Timeout:
  - A per-channel counter runs while its FSM is not IDLE and resets on return to IDLE.
  - When the count reaches TIMEOUT_CYCLES, the sticky flag sets. The transaction is NOT aborted; the valid stays asserted.
  - The counter saturates.
  - timeout_clr clears the flags. If clr and set occur in the same cycle, set wins.

Decomposition:
- Axi4LiteGlobalsPkg:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Write and read FSM state typedefs.
- Sub-module axi4_lite_master_channel_timer: counter plus sticky flag. Instantiated once for write and once for read.

Test Plan:
- Zero-wait write: addr=0x10, data=0xA5A5_0001, strb=0xF, awready/wready/bvalid tied high with bresp=OKAY -> wr_done at accept+3, wr_resp=00, awaddr=0x10 and wdata matching during valid.
- Skewed write: wready high 3 cycles before awready, bvalid delayed 5 cycles with SLVERR -> wvalid drops first, awvalid held stable, bready high only in W_RESP, wr_resp=10.
- Concurrent read and write: rd_req addr=0x20, rdata=0xDEAD_BEEF, rresp=OKAY, issued the same cycle as a write -> both complete independently, rd_data=0xDEAD_BEEF, no cross-channel stall.
- Timeout: TIMEOUT_CYCLES=4, arready held low -> rd_timeout=1 after 4 cycles in R_ADDR, arvalid still 1; timeout_clr -> flag 0; arready then high -> read completes normally.
- Reset mid-transaction: aresetn low during W_RESP -> bready/awvalid/wvalid 0 immediately, no wr_done pulse; after release, wr_req_ready=1 and the next write completes.
- Spurious response: bvalid=1 while in W_IDLE -> bready stays 0, no wr_done pulse, state unchanged.

Source files
------------

// File: rtl/axi4_lite_master_handshake_engine_pkg.sv
// Shared types for the AXI4-Lite master handshake engine:
// response codes and the write/read FSM state encodings.
package axi4_lite_master_handshake_engine_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE      = 2'd0;
  localparam w_state_t W_ADDR_DATA = 2'd1;
  localparam w_state_t W_RESP      = 2'd2;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE = 2'd0;
  localparam r_state_t R_ADDR = 2'd1;
  localparam r_state_t R_DATA = 2'd2;

endpackage

// File: rtl/axi4_lite_master_handshake_engine_channel_timer.sv
// Per-channel wait counter with a sticky timeout flag; the counter saturates
// and a set in the same cycle as a clear wins.
module axi4_lite_master_channel_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic active,
  input  logic clr,
  output logic flag
);

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;
    logic          hit;

    // The flag rises on the same edge the count reaches TIMEOUT_CYCLES.
    assign hit = active && (cnt == LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else begin
        if (!active)         cnt <= '0;
        else if (cnt != MAX) cnt <= cnt + 1'b1;

        if (hit)      flag <= 1'b1;
        else if (clr) flag <= 1'b0;
      end
    end
  end else begin : g_off
    assign flag = 1'b0;
  end

endmodule

// File: rtl/axi4_lite_master_handshake_engine.sv
// AXI4-Lite master: turns single local write/read commands into AW/W/B and
// AR/R handshakes, one outstanding transaction per direction, all outputs registered.
module axi4_lite_master_handshake_engine
  import axi4_lite_master_handshake_engine_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [DATA_WIDTH-1:0]   wr_req_data,
  input  logic [DATA_WIDTH/8-1:0] wr_req_strb,
  output logic                    wr_done,
  output logic [1:0]              wr_resp,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  output logic                    rd_done,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              rd_resp,
  input  logic                    timeout_clr,
  output logic                    wr_timeout,
  output logic                    rd_timeout,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);

  w_state_t w_state;
  r_state_t r_state;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state      <= W_IDLE;
      wr_req_ready <= 1'b0;
      wr_done      <= 1'b0;
      wr_resp      <= '0;
      awvalid      <= 1'b0;
      awaddr       <= '0;
      wvalid       <= 1'b0;
      wdata        <= '0;
      wstrb        <= '0;
      bready       <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (w_state)
        W_IDLE: begin
          wr_req_ready <= 1'b1;
          if (wr_req_ready && wr_req_valid) begin
            awaddr       <= wr_req_addr;
            wdata        <= wr_req_data;
            wstrb        <= wr_req_strb;
            awvalid      <= 1'b1;
            wvalid       <= 1'b1;
            wr_req_ready <= 1'b0;
            w_state      <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // Each channel is finished once its valid has dropped or handshakes now.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready       <= 1'b0;
            wr_done      <= 1'b1;
            wr_resp      <= bresp;
            wr_req_ready <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= R_IDLE;
      rd_req_ready <= 1'b0;
      rd_done      <= 1'b0;
      rd_data      <= '0;
      rd_resp      <= '0;
      arvalid      <= 1'b0;
      araddr       <= '0;
      rready       <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (r_state)
        R_IDLE: begin
          rd_req_ready <= 1'b1;
          if (rd_req_ready && rd_req_valid) begin
            araddr       <= rd_req_addr;
            arvalid      <= 1'b1;
            rd_req_ready <= 1'b0;
            r_state      <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            rready       <= 1'b0;
            rd_done      <= 1'b1;
            rd_data      <= rdata;
            rd_resp      <= rresp;
            rd_req_ready <= 1'b1;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi4_lite_master_channel_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .active  (w_state != W_IDLE),
    .clr     (timeout_clr),
    .flag    (wr_timeout)
  );

  axi4_lite_master_channel_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .active  (r_state != R_IDLE),
    .clr     (timeout_clr),
    .flag    (rd_timeout)
  );

endmodule
